div8_seq: RTL

- Sequential 8-bit restoring divider: the inverse arithmetic counterpart to the team's 8-bit CLA add/sub block.
- Computes quotient and remainder by one trial-subtract per clock, using the same subtract-with-borrow method (b inverted, carry-in 1).
- Start/busy/done handshake, so a controller or datapath FSM can issue divides alongside the combinational adder.

---
 rtl/div8_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/div8_seq.sv
// Sequential restoring divider: one trial subtraction per clock with a start/busy/done handshake.
// Optional macro DIV8_SIGNED_EN selects two's-complement operands and enables the ovf flag.
module div8_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH:0]   p_trial_s;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] d_next_s;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] q_fin_s;
  logic [WIDTH-1:0] r_fin_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dz_r;
  logic             accept_s;
  logic             last_s;
  logic             no_borrow_s;

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s   = (cnt_r == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_next_s = (b == '0) ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // One restoring step; the stored remainder is always below b so it fits WIDTH bits,
  // while the trial difference keeps WIDTH+1 bits to expose the borrow.
  always_comb begin
    p_shift_s   = {p_r, d_r[WIDTH-1]};
    p_trial_s   = p_shift_s + ~{1'b0, b_r} + (WIDTH+1)'(1);
    no_borrow_s = ~p_trial_s[WIDTH];
    p_next_s    = no_borrow_s ? p_trial_s[WIDTH-1:0] : p_shift_s[WIDTH-1:0];
    d_next_s    = {d_r[WIDTH-2:0], no_borrow_s};
  end

`ifdef DIV8_SIGNED_EN
  logic sign_a_r;
  logic sign_b_r;
  logic ovf_pend_r;
  logic ovf_r;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Magnitudes going in, sign restoration coming out
  always_comb begin
    a_mag_s = a[WIDTH-1] ? negate(a) : a;
    b_mag_s = b[WIDTH-1] ? negate(b) : b;
    q_fin_s = (sign_a_r ^ sign_b_r) ? negate(d_next_s) : d_next_s;
    r_fin_s = sign_a_r ? negate(p_next_s) : p_next_s;
  end

  // Operand signs and the most-negative / -1 overflow case
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      ovf_pend_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (accept_s) begin
      sign_a_r   <= a[WIDTH-1];
      sign_b_r   <= b[WIDTH-1];
      ovf_pend_r <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      ovf_r      <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      ovf_r <= ovf_pend_r;
    end
  end

  assign ovf = ovf_r;
`else
  always_comb begin
    a_mag_s = a;
    b_mag_s = b;
    q_fin_s = d_next_s;
    r_fin_s = p_next_s;
  end

  assign ovf = 1'b0;
`endif

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      d_r   <= '0;
      p_r   <= '0;
      b_r   <= '0;
      cnt_r <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dz_r  <= 1'b0;
    end else if (accept_s) begin
      if (b == '0) begin
        q_r  <= '1;
        r_r  <= a;
        dz_r <= 1'b1;
      end else begin
        d_r   <= a_mag_s;
        p_r   <= '0;
        b_r   <= b_mag_s;
        cnt_r <= CNT_W'(WIDTH);
        dz_r  <= 1'b0;
      end
    end else if (state_r == RUN) begin
      d_r   <= d_next_s;
      p_r   <= p_next_s;
      cnt_r <= cnt_r - CNT_W'(1);
      if (last_s) begin
        q_r <= q_fin_s;
        r_r <= r_fin_s;
      end
    end
  end

  assign q  = q_r;
  assign r  = r_r;
  assign dz = dz_r;

endmodule
